// File: rtl/life_seq_ctrl.sv
// life_seq_ctrl: Game-of-Life sequencer; key-release edit cursor, run/step FSM, generation framing.
//   Parameters: X, Y board size in cells; LOG2X, LOG2Y cursor widths (2**LOG2X >= X, 2**LOG2Y >= Y).
//   Ports: clk; reset (sync, active-high); keys[2:0] key code; tick generation-rate pulse;
//          nxt_bit high while a generation streams through the serial datapath;
//          phase bit position of the rotating board (0..X*Y-1); cursor_x, cursor_y edit cursor;
//          running run-mode flag; gen_count completed generations.
//   Key codes: none=0 up=1 down=2 left=3 right=4 flip=5 (ignored here) run=6 step=7.
//   Macro LIFE_GEN_COUNTER_EN: when defined gen_count counts generations, otherwise it is tied to 0.
module life_seq_ctrl #(
  parameter int X = 8,
  parameter int Y = 8,
  parameter int LOG2X = 3,
  parameter int LOG2Y = 3
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [2:0]             keys,
  input  logic                   tick,
  output logic                   nxt_bit,
  output logic [LOG2X+LOG2Y-1:0] phase,
  output logic [LOG2X-1:0]       cursor_x,
  output logic [LOG2Y-1:0]       cursor_y,
  output logic                   running,
  output logic [15:0]            gen_count
);
  localparam logic [2:0] KEY_NONE  = 3'd0;
  localparam logic [2:0] KEY_UP    = 3'd1;
  localparam logic [2:0] KEY_DOWN  = 3'd2;
  localparam logic [2:0] KEY_LEFT  = 3'd3;
  localparam logic [2:0] KEY_RIGHT = 3'd4;
  localparam logic [2:0] KEY_RUN   = 3'd6;
  localparam logic [2:0] KEY_STEP  = 3'd7;
  localparam int PW = LOG2X + LOG2Y;
  localparam logic [PW-1:0] LAST = PW'(X * Y - 1);
  localparam logic [LOG2X-1:0] XMAX = LOG2X'(X - 1);
  localparam logic [LOG2Y-1:0] YMAX = LOG2Y'(Y - 1);
  typedef enum logic [1:0] {PAUSE, WAIT_TICK, ARM, GEN} state_t;
  state_t state;
  logic [2:0] prev_keys;
  logic single, pending;
  logic rel_up, rel_down, rel_left, rel_right, rel_run, rel_step;
  logic last_ph, run_nx;
  // an action fires once, on the cycle the held code is released
  assign rel_up    = prev_keys == KEY_UP    && keys != KEY_UP;
  assign rel_down  = prev_keys == KEY_DOWN  && keys != KEY_DOWN;
  assign rel_left  = prev_keys == KEY_LEFT  && keys != KEY_LEFT;
  assign rel_right = prev_keys == KEY_RIGHT && keys != KEY_RIGHT;
  assign rel_run   = prev_keys == KEY_RUN   && keys != KEY_RUN;
  assign rel_step  = prev_keys == KEY_STEP  && keys != KEY_STEP;
  assign last_ph   = phase == LAST;
  assign run_nx    = running ^ rel_run;
  always_ff @(posedge clk) begin
    if (reset) phase <= '0;
    else phase <= last_ph ? '0 : phase + 1'b1;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      prev_keys <= KEY_NONE;
      cursor_x  <= '0;
      cursor_y  <= '0;
    end else begin
      prev_keys <= keys;
      if (rel_right) cursor_x <= cursor_x == XMAX ? '0 : cursor_x + 1'b1;
      if (rel_left)  cursor_x <= cursor_x == '0 ? XMAX : cursor_x - 1'b1;
      if (rel_down)  cursor_y <= cursor_y == YMAX ? '0 : cursor_y + 1'b1;
      if (rel_up)    cursor_y <= cursor_y == '0 ? YMAX : cursor_y - 1'b1;
    end
  end
  // ticks outside WAIT_TICK collapse into one pending request; WAIT_TICK consumes it
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= PAUSE;
      nxt_bit <= 1'b0;
      running <= 1'b0;
      single  <= 1'b0;
      pending <= 1'b0;
    end else begin
      pending <= state == WAIT_TICK ? 1'b0 : pending | tick;
      case (state)
        PAUSE:
          if (rel_run) begin
            running <= 1'b1;
            state   <= WAIT_TICK;
          end else if (rel_step && !running) begin
            single <= 1'b1;
            state  <= ARM;
          end
        WAIT_TICK:
          if (pending || tick) begin
            running <= run_nx;
            state   <= ARM;
          end else if (rel_run) begin
            running <= 1'b0;
            state   <= PAUSE;
          end
        ARM: begin
          running <= run_nx;
          if (last_ph) begin
            nxt_bit <= 1'b1;
            state   <= GEN;
          end
        end
        GEN: begin
          running <= run_nx;
          if (last_ph) begin
            nxt_bit <= 1'b0;
            single  <= 1'b0;
            state   <= (single || !run_nx) ? PAUSE : WAIT_TICK;
          end
        end
      endcase
    end
  end
`ifdef LIFE_GEN_COUNTER_EN
  always_ff @(posedge clk) begin
    if (reset) gen_count <= '0;
    else if (state == GEN && last_ph) gen_count <= gen_count + 1'b1;
  end
`else
  assign gen_count = '0;
`endif
endmodule

// File: tb/tb_life_seq_ctrl.sv
// tb_life_seq_ctrl: directed plus randomized checks of life_seq_ctrl against arithmetic expectations.
module tb_life_seq_ctrl;
  localparam int X = 8, Y = 8, N = X * Y;
  localparam logic [2:0] K_NONE = 3'd0, K_UP = 3'd1, K_DOWN = 3'd2, K_LEFT = 3'd3;
  localparam logic [2:0] K_RIGHT = 3'd4, K_FLIP = 3'd5, K_RUN = 3'd6, K_STEP = 3'd7;
`ifdef LIFE_GEN_COUNTER_EN
  localparam int GCI = 1;
`else
  localparam int GCI = 0;
`endif
  logic clk = 1'b0, reset = 1'b1, tick = 1'b0;
  logic [2:0] keys = K_NONE;
  logic nxt_bit, running;
  logic [5:0] phase;
  logic [2:0] cx, cy;
  logic [15:0] gen_count;
  logic reset5 = 1'b1, tick5 = 1'b0;
  logic [2:0] keys5 = K_NONE;
  logic nxt5, run5;
  logic [4:0] phase5;
  logic [2:0] cx5;
  logic [1:0] cy5;
  logic [15:0] gc5;
  int tests = 0, fails = 0;
  int ex = 0, ey = 0, egc = 0;
  always #5 clk = ~clk;
  life_seq_ctrl dut (
    .clk(clk), .reset(reset), .keys(keys), .tick(tick), .nxt_bit(nxt_bit), .phase(phase),
    .cursor_x(cx), .cursor_y(cy), .running(running), .gen_count(gen_count)
  );
  life_seq_ctrl #(.X(5), .Y(3), .LOG2X(3), .LOG2Y(2)) dut5 (
    .clk(clk), .reset(reset5), .keys(keys5), .tick(tick5), .nxt_bit(nxt5), .phase(phase5),
    .cursor_x(cx5), .cursor_y(cy5), .running(run5), .gen_count(gc5)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic press(input logic [2:0] k, input int hold);
    keys = k;
    step(hold);
    keys = K_NONE;
    step(1);
  endtask
  task automatic pulse_tick();
    tick = 1'b1;
    step(1);
    tick = 1'b0;
  endtask
  task automatic wait_nxt();
    int w = 0;
    while (!nxt_bit && w < 4 * N) begin
      step(1);
      w++;
    end
    chk("gen_started", nxt_bit, 1);
  endtask
  task automatic meas_gen(input int act_at, output int st, output int len);
    st = -1;
    len = 0;
    wait_nxt();
    if (nxt_bit) st = int'(phase);
    while (nxt_bit && len < 2 * N) begin
      if (len == act_at) keys = K_RUN;
      if (len == act_at + 2) keys = K_NONE;
      len++;
      step(1);
    end
  endtask
  task automatic quiet(input int n, output int hi);
    hi = 0;
    repeat (n) begin
      step(1);
      if (nxt_bit) hi++;
    end
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    int p, k, st, len, hi, mx, w;
    step(3);
    chk("rst_nxt", nxt_bit, 0);
    chk("rst_phase", phase, 0);
    chk("rst_cx", cx, 0);
    chk("rst_cy", cy, 0);
    chk("rst_running", running, 0);
    chk("rst_gc", gen_count, 0);
    reset = 1'b0;
    reset5 = 1'b0;
    step(1);
    chk("phase_after_rst", phase, 1);
    for (int i = 0; i < 3; i++) begin
      p = int'(phase);
      k = $urandom_range(1, 300);
      step(k);
      chk("phase_mod", phase, (p + k) % N);
    end
    w = 0;
    while (phase != 6'(N - 1) && w < 2 * N) begin step(1); w++; end
    step(1);
    chk("phase_wrap", phase, 0);
    press(K_LEFT, 2);
    chk("cur_left_wrap", cx, 7);
    press(K_UP, 2);
    chk("cur_up_wrap", cy, 7);
    press(K_RIGHT, 2);
    chk("cur_right_wrap", cx, 0);
    press(K_RIGHT, 50);
    chk("cur_hold50", cx, 1);
    ex = 1;
    ey = 7;
    for (int i = 0; i < 12; i++) begin
      k = $urandom_range(1, 5);
      press(3'(k), $urandom_range(1, 50));
      if (k == 1) ey = (ey + Y - 1) % Y;
      if (k == 2) ey = (ey + 1) % Y;
      if (k == 3) ex = (ex + X - 1) % X;
      if (k == 4) ex = (ex + 1) % X;
      chk("cur_rand_x", cx, ex);
      chk("cur_rand_y", cy, ey);
    end
    press(K_STEP, 3);
    meas_gen(-1, st, len);
    egc += GCI;
    chk("step_start_phase", st, 0);
    chk("step_len", len, N);
    chk("step_running", running, 0);
    chk("step_gc", gen_count, egc);
    quiet(150, hi);
    chk("step_then_pause", hi, 0);
    w = 0;
    while (phase5 != 5'd14 && w < 40) begin step(1); w++; end
    step(1);
    chk("p5_wrap", phase5, 0);
    mx = 0;
    repeat (45) begin
      step(1);
      if (int'(phase5) > mx) mx = int'(phase5);
    end
    chk("p5_max", mx, 14);
    keys5 = K_STEP;
    step(2);
    keys5 = K_NONE;
    w = 0;
    while (!nxt5 && w < 60) begin step(1); w++; end
    chk("g5_started", nxt5, 1);
    chk("g5_start_phase", phase5, 0);
    len = 0;
    while (nxt5 && len < 40) begin len++; step(1); end
    chk("g5_len", len, 15);
    chk("g5_gc", gc5, GCI);
    press(K_RUN, 2);
    chk("run_on", running, 1);
    press(K_STEP, 2);
    quiet(150, hi);
    chk("step_ignored_running", hi, 0);
    for (int i = 0; i < 3; i++) begin
      step($urandom_range(150, 250));
      pulse_tick();
      meas_gen(-1, st, len);
      egc += GCI;
      chk("run_start_phase", st, 0);
      chk("run_len", len, N);
      chk("run_gc", gen_count, egc);
      chk("run_still", running, 1);
    end
    quiet(200, hi);
    chk("run_no_tick_idle", hi, 0);
    pulse_tick();
    step(2);
    pulse_tick();
    step(2);
    pulse_tick();
    meas_gen(-1, st, len);
    chk("multi_gen1_len", len, N);
    meas_gen(-1, st, len);
    egc += 2 * GCI;
    chk("multi_gen2_start", st, 0);
    chk("multi_gen2_len", len, N);
    quiet(200, hi);
    chk("multi_collapsed", hi, 0);
    chk("multi_gc", gen_count, egc);
    pulse_tick();
    meas_gen(8, st, len);
    egc += GCI;
    chk("stop_mid_start", st, 0);
    chk("stop_mid_len", len, N);
    chk("stop_mid_running", running, 0);
    chk("stop_mid_gc", gen_count, egc);
    pulse_tick();
    quiet(200, hi);
    chk("stop_paused", hi, 0);
    press(K_STEP, 2);
    wait_nxt();
    step(30);
    pulse_tick();
    reset = 1'b1;
    step(1);
    chk("rgen_nxt", nxt_bit, 0);
    chk("rgen_phase", phase, 0);
    chk("rgen_cx", cx, 0);
    chk("rgen_cy", cy, 0);
    chk("rgen_running", running, 0);
    chk("rgen_gc", gen_count, 0);
    reset = 1'b0;
    press(K_RUN, 2);
    quiet(200, hi);
    chk("rgen_pending_cleared", hi, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
